// File: rtl/fsm_trace_monitor.sv
// fsm_trace_monitor: samples a 2-bit Moore state, queues transition events
// with dwell times, flags a 4-state visit sequence. Opt: TRACE_ILLEGAL_CHECK_EN.
module fsm_trace_monitor #(
  parameter int          DEPTH      = 4,
  parameter int          CNT_W      = 8,
  parameter logic [7:0]  SEQ        = 8'b00_11_01_10,
  parameter logic [15:0] LEGAL_MASK = 16'hFFFF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       A,
  input  logic                       B,
  input  logic                       evt_ready,
  output logic                       evt_valid,
  output logic [1:0]                 evt_from,
  output logic [1:0]                 evt_to,
  output logic [CNT_W-1:0]           evt_dwell,
  output logic [$clog2(DEPTH+1)-1:0] evt_count,
  output logic                       overflow,
  output logic                       seq_hit
`ifdef TRACE_ILLEGAL_CHECK_EN
  ,
  output logic                       illegal
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int EW = CNT_W + 4;

  typedef enum logic {
    ST_PRIME,
    ST_RUN
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [1:0]       w_st;
  logic             w_prime;
  logic             w_trans;

  logic [1:0]       r_prev;
  logic [CNT_W-1:0] r_dwell;
  logic [CNT_W-1:0] w_dwell_inc;
  logic [7:0]       r_hist;
  logic [7:0]       w_hist_nxt;
  logic [2:0]       r_hcnt;
  logic [2:0]       w_hcnt_nxt;
  logic             w_seq_match;
  logic             r_seq_hit;

  logic [EW-1:0]    r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             r_ovf;
  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic [EW-1:0]    w_head;

  assign w_st = {A, B};

  // State register: unprimed after reset, running once a sample is held.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_PRIME;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state plus prime/transition strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_prime     = 1'b0;
    w_trans     = 1'b0;
    unique case (r_state)
      ST_PRIME: begin
        w_prime     = 1'b1;
        w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        w_trans = (w_st != r_prev);
      end
      default: begin
        w_state_nxt = ST_PRIME;
      end
    endcase
  end

  assign w_dwell_inc = (&r_dwell) ? r_dwell
                     : r_dwell + CNT_W'(1);
  assign w_hist_nxt  = {r_hist[5:0], w_st};
  assign w_hcnt_nxt  = (r_hcnt == 3'd4) ? 3'd4
                     : r_hcnt + 3'd1;
  assign w_seq_match = w_trans
                     && (w_hist_nxt == SEQ)
                     && (w_hcnt_nxt == 3'd4);

  // Track previous state, dwell length and entered-state history.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev  <= 2'b00;
      r_dwell <= '0;
      r_hist  <= 8'h00;
      r_hcnt  <= 3'd0;
    end else if (w_prime) begin
      r_prev  <= w_st;
      r_dwell <= CNT_W'(1);
      r_hist  <= {6'b0, w_st};
      r_hcnt  <= 3'd1;
    end else if (w_trans) begin
      r_prev  <= w_st;
      r_dwell <= CNT_W'(1);
      r_hist  <= w_hist_nxt;
      r_hcnt  <= w_hcnt_nxt;
    end else begin
      r_dwell <= w_dwell_inc;
    end
  end

  // One-cycle pulse after the edge that completes the sequence.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_seq_hit <= 1'b0;
    end else begin
      r_seq_hit <= w_seq_match;
    end
  end

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_pop   = !w_empty && evt_ready;
  // A pop in the same cycle frees the slot a full FIFO needs.
  assign w_push  = w_trans && (!w_full || w_pop);
  assign w_drop  = w_trans && w_full && !w_pop;

  // Event storage; contents are only meaningful behind the pointers.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {r_prev, w_st, r_dwell};
    end
  end

  // Pointers, occupancy and sticky overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end
      if (w_drop) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign w_head    = r_mem[r_rptr];
  assign evt_valid = !w_empty;
  assign evt_from  = evt_valid ? w_head[EW-1:EW-2] : 2'b00;
  assign evt_to    = evt_valid ? w_head[EW-3:EW-4] : 2'b00;
  assign evt_dwell = evt_valid ? w_head[CNT_W-1:0] : '0;
  assign evt_count = r_count;
  assign overflow  = r_ovf;
  assign seq_hit   = r_seq_hit;

`ifdef TRACE_ILLEGAL_CHECK_EN
  logic r_illegal;

  // Sticky flag for any transition the legality mask forbids.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_illegal <= 1'b0;
    end else if (w_trans && !LEGAL_MASK[{r_prev, w_st}]) begin
      r_illegal <= 1'b1;
    end
  end

  assign illegal = r_illegal;
`else
  logic w_unused_mask;
  assign w_unused_mask = ^LEGAL_MASK;
`endif

endmodule

// File: tb/tb_fsm_trace_monitor.sv
// tb_fsm_trace_monitor: directed stimulus, queue-based reference model
// compared every cycle, plus literal spot checks.
module tb_fsm_trace_monitor;

  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
  localparam int CW    = 3;
  localparam int DMAX  = 15;
`ifdef TRACE_ILLEGAL_CHECK_EN
  localparam logic [15:0] MASK = 16'hEFFF;
`else
  localparam logic [15:0] MASK = 16'hFFFF;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             A = 1'b0;
  logic             B = 1'b0;
  logic             evt_ready = 1'b0;
  logic             evt_valid;
  logic [1:0]       evt_from;
  logic [1:0]       evt_to;
  logic [CNT_W-1:0] evt_dwell;
  logic [CW-1:0]    evt_count;
  logic             overflow;
  logic             seq_hit;
`ifdef TRACE_ILLEGAL_CHECK_EN
  logic             illegal;
`endif

  fsm_trace_monitor #(
    .DEPTH(DEPTH),
    .CNT_W(CNT_W),
    .SEQ(8'b00_11_01_10),
    .LEGAL_MASK(MASK)
  ) dut (
    .clk(clk),
    .reset(reset),
    .A(A),
    .B(B),
    .evt_ready(evt_ready),
    .evt_valid(evt_valid),
    .evt_from(evt_from),
    .evt_to(evt_to),
    .evt_dwell(evt_dwell),
    .evt_count(evt_count),
    .overflow(overflow),
    .seq_hit(seq_hit)
`ifdef TRACE_ILLEGAL_CHECK_EN
    ,
    .illegal(illegal)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  typedef struct {
    int f_st;
    int t_st;
    int dw;
  } ev_t;

  ev_t q[$];
  int  m_hist[$];
  bit  m_primed;
  int  m_prev;
  int  m_dwell;
  bit  m_ovf;
  bit  m_hit;
  bit  m_ill;
  int  m_st;
  ev_t m_e;

  task automatic cmp(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d t=%0t", n, act, exp, $time);
    end
  endtask

  // Reference model: events are a queue, history is the last four states.
  always @(posedge clk) begin
    m_st = int'({A, B});
    if (reset) begin
      q.delete();
      m_hist.delete();
      m_primed = 1'b0;
      m_dwell  = 0;
      m_ovf    = 1'b0;
      m_hit    = 1'b0;
      m_ill    = 1'b0;
    end else begin
      m_hit = 1'b0;
      if (q.size() > 0 && evt_ready) begin
        void'(q.pop_front());
      end
      if (!m_primed) begin
        m_primed = 1'b1;
        m_prev   = m_st;
        m_dwell  = 1;
        m_hist.push_back(m_st);
      end else if (m_st == m_prev) begin
        if (m_dwell < DMAX) m_dwell++;
      end else begin
        m_e.f_st = m_prev;
        m_e.t_st = m_st;
        m_e.dw   = m_dwell;
        if (q.size() < DEPTH) q.push_back(m_e);
        else m_ovf = 1'b1;
        if (!MASK[m_prev*4 + m_st]) m_ill = 1'b1;
        m_hist.push_back(m_st);
        if (m_hist.size() > 4) void'(m_hist.pop_front());
        if (m_hist.size() == 4 && m_hist[0] == 0 && m_hist[1] == 3
            && m_hist[2] == 1 && m_hist[3] == 2) m_hit = 1'b1;
        m_prev  = m_st;
        m_dwell = 1;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      cmp("valid", int'(evt_valid), int'(q.size() > 0));
      cmp("count", int'(evt_count), q.size());
      cmp("overflow", int'(overflow), int'(m_ovf));
      cmp("seq_hit", int'(seq_hit), int'(m_hit));
`ifdef TRACE_ILLEGAL_CHECK_EN
      cmp("illegal", int'(illegal), int'(m_ill));
`endif
      if (q.size() > 0) begin
        cmp("from", int'(evt_from), q[0].f_st);
        cmp("to", int'(evt_to), q[0].t_st);
        cmp("dwell", int'(evt_dwell), q[0].dw);
      end
    end
  end

  task automatic cyc(input logic [1:0] s, input logic r);
    {A, B}    = s;
    evt_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset     = 1'b1;
    evt_ready = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
  endtask

  initial begin
    do_reset(2);
    chk_on = 1'b1;
    cmp("rst_valid", int'(evt_valid), 0);
    cmp("rst_count", int'(evt_count), 0);
    cmp("rst_ovf", int'(overflow), 0);
    cmp("rst_hit", int'(seq_hit), 0);

    repeat (3) cyc(2'b00, 1'b0);
    cmp("t1_none", int'(evt_valid), 0);
    cyc(2'b11, 1'b0);
    cmp("t1_valid", int'(evt_valid), 1);
    cmp("t1_from", int'(evt_from), 0);
    cmp("t1_to", int'(evt_to), 3);
    cmp("t1_dwell", int'(evt_dwell), 3);
    cyc(2'b11, 1'b0);
    cmp("t1_count", int'(evt_count), 1);

    do_reset(1);
    cyc(2'b00, 1'b1);
    cyc(2'b11, 1'b1);
    cyc(2'b01, 1'b1);
    cmp("t2_early", int'(seq_hit), 0);
    cyc(2'b10, 1'b1);
    cmp("t2_hit", int'(seq_hit), 1);
    cyc(2'b10, 1'b1);
    cmp("t2_hit_off", int'(seq_hit), 0);
    cyc(2'b00, 1'b1);
    cyc(2'b00, 1'b1);
    cyc(2'b00, 1'b1);

    do_reset(1);
    cyc(2'b00, 1'b0);
    for (int i = 0; i < 6; i++) begin
      cyc((i % 2 == 0) ? 2'b01 : 2'b00, 1'b0);
    end
    cmp("t3_count", int'(evt_count), 4);
    cmp("t3_ovf", int'(overflow), 1);
    cmp("t3_from0", int'(evt_from), 0);
    cmp("t3_to0", int'(evt_to), 1);
    cyc(2'b00, 1'b1);
    cmp("t3_from1", int'(evt_from), 1);
    cmp("t3_to1", int'(evt_to), 0);
    repeat (4) cyc(2'b00, 1'b1);
    cmp("t3_empty", int'(evt_count), 0);
    cmp("t3_sticky", int'(overflow), 1);

    do_reset(1);
    cyc(2'b00, 1'b0);
    cyc(2'b01, 1'b0);
    cyc(2'b00, 1'b0);
    cyc(2'b01, 1'b0);
    cyc(2'b00, 1'b0);
    cmp("t4_full", int'(evt_count), 4);
    cyc(2'b01, 1'b1);
    cmp("t4_count", int'(evt_count), 4);
    cmp("t4_ovf", int'(overflow), 0);
    cmp("t4_head", int'(evt_from), 1);
    cyc(2'b01, 1'b0);

    do_reset(1);
    repeat (20) cyc(2'b10, 1'b0);
    cyc(2'b00, 1'b0);
    cmp("t5_from", int'(evt_from), 2);
    cmp("t5_dwell", int'(evt_dwell), 15);

    do_reset(1);
    cyc(2'b00, 1'b0);
    cyc(2'b11, 1'b0);
    cyc(2'b00, 1'b0);
    cmp("t6_two", int'(evt_count), 2);
`ifdef TRACE_ILLEGAL_CHECK_EN
    cmp("t6_illegal", int'(illegal), 1);
`endif
    do_reset(1);
    cmp("t6_valid", int'(evt_valid), 0);
    cmp("t6_count", int'(evt_count), 0);
    cmp("t6_ovf", int'(overflow), 0);
`ifdef TRACE_ILLEGAL_CHECK_EN
    cmp("t6_ill_clr", int'(illegal), 0);
`endif
    cyc(2'b01, 1'b0);
    cyc(2'b01, 1'b0);
    cyc(2'b01, 1'b0);
    cyc(2'b10, 1'b0);
    cmp("t6_from", int'(evt_from), 1);
    cmp("t6_to", int'(evt_to), 2);
    cmp("t6_dwell", int'(evt_dwell), 3);
    cyc(2'b10, 1'b0);

    chk_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
